// File: rtl/kstream_pkg.sv
// Shared types and parameter-derived constants for the kstream sequencer.
// The optional KSTREAM_THROTTLE_EN build uses LFSR_SEED from here.
package kstream_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   // Index of the final beat of one work instance, padding included.
   function automatic int unsigned lastIdx(input int size, input int lat, input int iovect);
      return int'(size - iovect + lat * iovect);
   endfunction

   function automatic int unsigned padStart(input int size);
      return size;
   endfunction

   function automatic int unsigned outStart(input int lat, input int iovect);
      return lat * iovect;
   endfunction

endpackage

// File: rtl/kstream_seq_if.sv
// Bundle of the sequencer's launch, kernel-handshake and buffer-address signals.
// master is the sequencer side; slave is the buffer/DMA or bench side.
interface kstream_seq_if #(
   parameter int DATAW = 32
);

   logic             start;
   logic             src_ok;
   logic             k_ovalid;
   logic             k_ivalid;
   logic             in_rd_en;
   logic [DATAW-1:0] in_addr;
   logic             pad;
   logic             out_wr_en;
   logic [DATAW-1:0] out_addr;
   logic [DATAW-1:0] lincount;
   logic [DATAW-1:0] wi_count;
   logic             busy;
   logic             done;
   logic             err_ovalid;

   modport master (
      input  start, src_ok, k_ovalid,
      output k_ivalid, in_rd_en, in_addr, pad, out_wr_en, out_addr,
             lincount, wi_count, busy, done, err_ovalid
   );

   modport slave (
      output start, src_ok, k_ovalid,
      input  k_ivalid, in_rd_en, in_addr, pad, out_wr_en, out_addr,
             lincount, wi_count, busy, done, err_ovalid
   );

endinterface

// File: rtl/kstream_throttle.sv
// Pseudo-random back-pressure generator, only instantiated when KSTREAM_THROTTLE_EN is defined.
// 16-bit Fibonacci LFSR (taps 16,14,13,11) plus a 2-bit hold counter.
module kstream_throttle
   import kstream_pkg::*;
(
   input  logic clock,
   input  logic resetn,
   input  logic en,
   output logic throttle
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;
   logic [1:0]  hold_q;
   logic        trigger;

   always_comb begin
      lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      trigger = (lfsr_q[3:0] == 4'd0);
   end

   assign throttle = en & (trigger | (hold_q != 2'd0));

   // A trigger stalls this cycle and loads a further 0-3 cycles of stall.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         lfsr_q <= LFSR_SEED;
         hold_q <= 2'd0;
      end else if (en) begin
         lfsr_q <= lfsr_d;
         if (hold_q != 2'd0) begin
            hold_q <= hold_q - 2'd1;
         end else if (trigger) begin
            hold_q <= lfsr_q[5:4];
         end
      end
   end

endmodule

// File: rtl/kstream_seq.sv
// Index/address sequencer for the fixed-latency streaming kernel, padding each work instance.
// Define KSTREAM_THROTTLE_EN to add LFSR-driven back-pressure via kstream_throttle.
module kstream_seq
   import kstream_pkg::*;
#(
   parameter int DATAW      = 32,
   parameter int SIZE       = 1024,
   parameter int IN_OUT_LAT = 8,
   parameter int IOVECT     = 1,
   parameter int NWI        = 1
) (
   input  logic          clock,
   input  logic          resetn,
   kstream_seq_if.master bus
);

   localparam logic [DATAW-1:0] LAST_IDX  = DATAW'(lastIdx(SIZE, IN_OUT_LAT, IOVECT));
   localparam logic [DATAW-1:0] PAD_START = DATAW'(padStart(SIZE));
   localparam logic [DATAW-1:0] OUT_START = DATAW'(outStart(IN_OUT_LAT, IOVECT));
   localparam logic [DATAW-1:0] STEP      = DATAW'(IOVECT);
   localparam logic [DATAW-1:0] NWI_C     = DATAW'(NWI);

   state_e           state_q;
   logic [DATAW-1:0] linCount_q;
   logic [DATAW-1:0] linCount_d;
   logic [DATAW-1:0] wiCount_q;
   logic [DATAW-1:0] wiCount_d;
   logic             errOvalid_q;
   logic             throttle;
   logic             beat;
   logic             wrap;
   logic             outWr;

`ifdef KSTREAM_THROTTLE_EN
   kstream_throttle u_throttle (
      .clock    (clock),
      .resetn   (resetn),
      .en       (state_q == RUN),
      .throttle (throttle)
   );
`else
   assign throttle = 1'b0;
`endif

   assign beat  = (state_q == RUN) & bus.src_ok & ~throttle;
   assign outWr = beat & (linCount_q >= OUT_START);

   always_comb begin
      wrap       = (linCount_q == LAST_IDX);
      linCount_d = wrap ? '0 : linCount_q + STEP;
      wiCount_d  = wrap ? wiCount_q + DATAW'(1) : wiCount_q;
   end

   // Counters only move on an issued beat; the last beat of the last instance ends the run.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q     <= IDLE;
         linCount_q  <= '0;
         wiCount_q   <= '0;
         errOvalid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_q     <= RUN;
                  linCount_q  <= '0;
                  wiCount_q   <= '0;
                  errOvalid_q <= 1'b0;
               end
            end
            RUN: begin
               if (bus.k_ovalid != outWr) begin
                  errOvalid_q <= 1'b1;
               end
               if (beat) begin
                  linCount_q <= linCount_d;
                  wiCount_q  <= wiCount_d;
                  if (wrap && (wiCount_d == NWI_C)) begin
                     state_q <= DONE;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.k_ivalid   = beat;
   assign bus.in_rd_en   = beat & (linCount_q < PAD_START);
   assign bus.pad        = beat & (linCount_q >= PAD_START);
   assign bus.out_wr_en  = outWr;
   assign bus.in_addr    = linCount_q;
   assign bus.out_addr   = linCount_q - OUT_START;
   assign bus.lincount   = linCount_q;
   assign bus.wi_count   = wiCount_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.done       = (state_q == DONE);
   assign bus.err_ovalid = errOvalid_q;

endmodule

// File: tb/tb_kstream_seq.sv
// Self-checking bench for kstream_seq: three instances (basic, NWI=3, SIZE=64) against a beat-count model.
// Also builds with KSTREAM_THROTTLE_EN; the model then accepts the DUT's stall decisions.
module tb_kstream_seq;

   logic clock;
   logic resetn;
   logic startReq;
   logic srcOk;
   logic kOvalid;
   logic [1:0] sel;

   int checks;
   int errors;

   kstream_seq_if #(.DATAW(32)) ifA ();
   kstream_seq_if #(.DATAW(32)) ifB ();
   kstream_seq_if #(.DATAW(32)) ifC ();

   assign ifA.start    = startReq && (sel == 2'd0);
   assign ifB.start    = startReq && (sel == 2'd1);
   assign ifC.start    = startReq && (sel == 2'd2);
   assign ifA.src_ok   = srcOk;
   assign ifB.src_ok   = srcOk;
   assign ifC.src_ok   = srcOk;
   assign ifA.k_ovalid = kOvalid;
   assign ifB.k_ovalid = kOvalid;
   assign ifC.k_ovalid = kOvalid;

   kstream_seq #(.DATAW(32), .SIZE(8), .IN_OUT_LAT(3), .IOVECT(1), .NWI(1)) u_a (
      .clock(clock), .resetn(resetn), .bus(ifA.master));
   kstream_seq #(.DATAW(32), .SIZE(8), .IN_OUT_LAT(3), .IOVECT(1), .NWI(3)) u_b (
      .clock(clock), .resetn(resetn), .bus(ifB.master));
   kstream_seq #(.DATAW(32), .SIZE(64), .IN_OUT_LAT(3), .IOVECT(1), .NWI(1)) u_c (
      .clock(clock), .resetn(resetn), .bus(ifC.master));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [134:0] packObs(input logic iv, rd, pd, wr, bs, dn, er,
                                            input logic [31:0] lin, wi, ia, oa);
      return {iv, rd, pd, wr, bs, dn, er, lin, wi, rd ? ia : 32'd0, wr ? oa : 32'd0};
   endfunction

   logic [134:0] obsVec;
   logic [134:0] expVec;
   logic [31:0]  obsLin;
   logic [31:0]  obsWi;
   logic         obsIvalid, obsRd, obsWr, obsBusy, obsDone, obsErr;

   always_comb begin
      case (sel)
         2'd1: obsVec = packObs(ifB.k_ivalid, ifB.in_rd_en, ifB.pad, ifB.out_wr_en, ifB.busy, ifB.done,
                                ifB.err_ovalid, ifB.lincount, ifB.wi_count, ifB.in_addr, ifB.out_addr);
         2'd2: obsVec = packObs(ifC.k_ivalid, ifC.in_rd_en, ifC.pad, ifC.out_wr_en, ifC.busy, ifC.done,
                                ifC.err_ovalid, ifC.lincount, ifC.wi_count, ifC.in_addr, ifC.out_addr);
         default: obsVec = packObs(ifA.k_ivalid, ifA.in_rd_en, ifA.pad, ifA.out_wr_en, ifA.busy, ifA.done,
                                   ifA.err_ovalid, ifA.lincount, ifA.wi_count, ifA.in_addr, ifA.out_addr);
      endcase
   end

   assign obsIvalid = obsVec[134];
   assign obsRd     = obsVec[133];
   assign obsWr     = obsVec[131];
   assign obsBusy   = obsVec[130];
   assign obsDone   = obsVec[129];
   assign obsErr    = obsVec[128];
   assign obsLin    = obsVec[127:96];
   assign obsWi     = obsVec[95:64];

   // Reference model: a run is NWI*(SIZE/IOVECT+LAT) beats; beat k carries index (k mod per)*IOVECT.
   int mSize, mLat, mIov, mNwi;
   int beatIdx;
   bit mRunning, mDoneNow, mErr;
   int savedBeats [3];
   bit savedErr [3];

   task automatic setTarget(input int s);
      savedBeats[sel] = beatIdx;
      savedErr[sel]   = mErr;
      sel      = 2'(s);
      mSize    = (s == 2) ? 64 : 8;
      mLat     = 3;
      mIov     = 1;
      mNwi     = (s == 1) ? 3 : 1;
      beatIdx  = savedBeats[s];
      mErr     = savedErr[s];
      mRunning = 1'b0;
      mDoneNow = 1'b0;
   endtask

   task automatic advance(input bit st, input bit so, input int dropOut, input bit rstLow);
      int per, lin, wi, off;
      bit beat, rd, wr;
      @(posedge clock);
      #1;
      startReq = st;
      srcOk    = so;
      resetn   = ~rstLow;
      kOvalid  = 1'b0;
      #1;
      per  = mSize / mIov + mLat;
      off  = mLat * mIov;
      lin  = (beatIdx % per) * mIov;
      wi   = beatIdx / per;
      beat = mRunning && so;
`ifdef KSTREAM_THROTTLE_EN
      beat = beat && (obsIvalid === 1'b1);
`endif
      rd = beat && (lin < mSize);
      wr = beat && (lin >= off);
      kOvalid = wr ^ (wr && ((lin - off) == dropOut));
      expVec = packObs(beat, rd, beat && (lin >= mSize), wr, mRunning || mDoneNow, mDoneNow, mErr,
                       32'(lin), 32'(wi), 32'(lin), 32'(lin - off));
      if (rstLow) begin
         mRunning = 1'b0;
         mDoneNow = 1'b0;
         beatIdx  = 0;
         mErr     = 1'b0;
         foreach (savedBeats[i]) begin
            savedBeats[i] = 0;
            savedErr[i]   = 1'b0;
         end
      end else if (mRunning) begin
         if (kOvalid != wr) mErr = 1'b1;
         if (beat) beatIdx++;
         if (beatIdx == mNwi * per) begin
            mRunning = 1'b0;
            mDoneNow = 1'b1;
         end
      end else if (mDoneNow) begin
         mDoneNow = 1'b0;
      end else if (st) begin
         mRunning = 1'b1;
         beatIdx  = 0;
         mErr     = 1'b0;
      end
   endtask

   task automatic test_reset();
      setTarget(0);
      advance(1'b0, 1'b0, -1, 1'b1);
      advance(1'b0, 1'b0, -1, 1'b1);
      for (int c = 0; c < 3; c++) begin
         advance(1'b0, 1'b1, -1, 1'b0);
         checks++;
         if (obsVec !== expVec) begin
            errors++;
            $display("[TB] FAIL reset_idle cycle %0d: got %h expected %h", c, obsVec, expVec);
         end
      end
   endtask

   task automatic test_basic(input string name);
      int c, doneAt;
      setTarget(0);
      c = 0;
      doneAt = -1;
      do begin
         advance(c == 0, 1'b1, -1, 1'b0);
         checks++;
         if (obsVec !== expVec) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, c, obsVec, expVec);
         end
         if (obsDone === 1'b1) doneAt = c;
         c++;
      end while ((mRunning || mDoneNow) && c < 400);
      checks++;
      if (mRunning || mDoneNow) begin
         errors++;
         $display("[TB] FAIL %s_timeout: still busy after %0d cycles, required done", name, c);
      end
`ifndef KSTREAM_THROTTLE_EN
      checks++;
      if (doneAt != 12) begin
         errors++;
         $display("[TB] FAIL %s_done_cycle: got %0d expected 12", name, doneAt);
      end
`endif
      checks++;
      if (obsWi !== 32'd1) begin
         errors++;
         $display("[TB] FAIL %s_wi_count: got %0d expected 1", name, obsWi);
      end
      advance(1'b0, 1'b1, -1, 1'b0);
      checks++;
      if (obsBusy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s_busy_low: got %b expected 0", name, obsBusy);
      end
   endtask

   task automatic test_src_stall();
      int c, doneAt;
      setTarget(0);
      c = 0;
      doneAt = -1;
      do begin
         advance(c == 0, !(c >= 3 && c <= 5), -1, 1'b0);
         checks++;
         if (obsVec !== expVec) begin
            errors++;
            $display("[TB] FAIL stall cycle %0d: got %h expected %h", c, obsVec, expVec);
         end
         if (c == 4) begin
            checks++;
            if (obsLin !== 32'd2 || obsIvalid !== 1'b0) begin
               errors++;
               $display("[TB] FAIL stall_hold: lincount %0d ivalid %b expected 2 and 0", obsLin, obsIvalid);
            end
         end
         if (obsDone === 1'b1) doneAt = c;
         c++;
      end while ((mRunning || mDoneNow) && c < 400);
`ifndef KSTREAM_THROTTLE_EN
      checks++;
      if (doneAt != 15) begin
         errors++;
         $display("[TB] FAIL stall_done_cycle: got %0d expected 15", doneAt);
      end
`endif
   endtask

   task automatic test_multi_wi();
      int c, doneAt;
      setTarget(1);
      c = 0;
      doneAt = -1;
      do begin
         advance(c == 0, 1'b1, -1, 1'b0);
         checks++;
         if (obsVec !== expVec) begin
            errors++;
            $display("[TB] FAIL multi cycle %0d: got %h expected %h", c, obsVec, expVec);
         end
`ifndef KSTREAM_THROTTLE_EN
         if (c == 12) begin
            checks++;
            if (obsLin !== 32'd0 || obsWi !== 32'd1 || obsIvalid !== 1'b1) begin
               errors++;
               $display("[TB] FAIL multi_wrap: lin %0d wi %0d ivalid %b expected 0 1 1", obsLin, obsWi, obsIvalid);
            end
         end
`endif
         if (obsDone === 1'b1) doneAt = c;
         c++;
      end while ((mRunning || mDoneNow) && c < 400);
`ifndef KSTREAM_THROTTLE_EN
      checks++;
      if (doneAt != 34) begin
         errors++;
         $display("[TB] FAIL multi_done_cycle: got %0d expected 34", doneAt);
      end
`endif
      checks++;
      if (obsWi !== 32'd3) begin
         errors++;
         $display("[TB] FAIL multi_wi_count: got %0d expected 3", obsWi);
      end
   endtask

   task automatic test_reset_rearm();
      setTarget(0);
      for (int c = 0; c < 8; c++) begin
         advance(c == 0, 1'b1, -1, c == 6);
         checks++;
         if (obsVec !== expVec) begin
            errors++;
            $display("[TB] FAIL rearm cycle %0d: got %h expected %h", c, obsVec, expVec);
         end
      end
      checks++;
      if (obsBusy !== 1'b0 || obsLin !== 32'd0 || obsWi !== 32'd0 || obsErr !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rearm_cleared: busy %b lin %0d wi %0d err %b expected all 0",
                  obsBusy, obsLin, obsWi, obsErr);
      end
      test_basic("rearm");
   endtask

   task automatic test_throttled();
      int c, rdCnt, wrCnt;
      setTarget(2);
      c = 0;
      rdCnt = 0;
      wrCnt = 0;
      do begin
         advance(c == 0, $urandom_range(0, 3) != 0, -1, 1'b0);
         checks++;
         if (obsVec !== expVec) begin
            errors++;
            $display("[TB] FAIL throttled cycle %0d: got %h expected %h", c, obsVec, expVec);
         end
         if (obsRd === 1'b1) rdCnt++;
         if (obsWr === 1'b1) wrCnt++;
         c++;
      end while ((mRunning || mDoneNow) && c < 2000);
      checks++;
      if (rdCnt != 64 || wrCnt != 64) begin
         errors++;
         $display("[TB] FAIL throttled_counts: rd %0d wr %0d expected 64 64", rdCnt, wrCnt);
      end
   endtask

   task automatic test_ovalid_err();
      int c;
      setTarget(0);
      c = 0;
      do begin
         advance(c == 0, 1'b1, 4, 1'b0);
         checks++;
         if (obsVec !== expVec) begin
            errors++;
            $display("[TB] FAIL ovalid cycle %0d: got %h expected %h", c, obsVec, expVec);
         end
         c++;
      end while ((mRunning || mDoneNow) && c < 400);
      for (int i = 0; i < 2; i++) advance(1'b0, 1'b1, -1, 1'b0);
      checks++;
      if (obsErr !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ovalid_sticky: got %b expected 1", obsErr);
      end
   endtask

   task automatic test_start_mask();
      int c;
      setTarget(0);
      c = 0;
      do begin
         advance(c == 0 || c == 4 || c == 9, 1'b1, -1, 1'b0);
         checks++;
         if (obsVec !== expVec) begin
            errors++;
            $display("[TB] FAIL start_mask cycle %0d: got %h expected %h", c, obsVec, expVec);
         end
         if (c == 1) begin
            checks++;
            if (obsErr !== 1'b0) begin
               errors++;
               $display("[TB] FAIL start_clears_err: got %b expected 0", obsErr);
            end
         end
         c++;
      end while ((mRunning || mDoneNow) && c < 400);
      advance(1'b0, 1'b1, -1, 1'b0);
      checks++;
      if (obsBusy !== 1'b0 || obsWi !== 32'd1) begin
         errors++;
         $display("[TB] FAIL start_mask_end: busy %b wi %0d expected 0 1", obsBusy, obsWi);
      end
   endtask

   initial begin
      resetn   = 1'b0;
      startReq = 1'b0;
      srcOk    = 1'b0;
      kOvalid  = 1'b0;
      sel      = 2'd0;
      checks   = 0;
      errors   = 0;
      beatIdx  = 0;
      mErr     = 1'b0;
      foreach (savedBeats[i]) begin
         savedBeats[i] = 0;
         savedErr[i]   = 1'b0;
      end
      test_reset();
      test_basic("basic");
      test_src_stall();
      test_multi_wi();
      test_reset_rearm();
      test_throttled();
      test_ovalid_err();
      test_start_mask();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/kstream_seq.md
# kstream_seq

Sequencer for the fixed-latency streaming kernel (`func_hdl_top`). It walks a linear index over `SIZE` input elements and pads with `IN_OUT_LAT` zero beats so the pipeline drains. It drives the kernel's `ivalid`, generates read addresses for the input buffers and write-back addresses for the output buffers, and counts work instances. It sits between the on-chip buffer/DMA layer and the kernel top, replacing the hand-written index logic previously carried by each bench.

## Interface
Parameters:
- `DATAW`, 32: width of index, address and counter outputs.
- `SIZE`, 1024: elements per work instance; must be a multiple of `IOVECT`.
- `IN_OUT_LAT`, 8: kernel latency in valid beats.
- `IOVECT`, 1: elements consumed per beat.
- `NWI`, 1: work instances per `start`; must be ≥1.

Ports (one clock; reset is synchronous and active-low):
- `clock` in 1: clock.
- `resetn` in 1: synchronous active-low reset.
- `start` in 1: single-cycle launch request; sampled only in IDLE.
- `src_ok` in 1: input buffers can supply a beat this cycle.
- `k_ovalid` in 1: kernel `ovalid`, checked against expected write-back.
- `k_ivalid` out 1: beat issued to kernel this cycle.
- `in_rd_en` out 1: read input buffers at `in_addr`.
- `in_addr` out DATAW: input element index (= `lincount`).
- `pad` out 1: beat is zero padding; input muxes drive 0.
- `out_wr_en` out 1: write kernel output at `out_addr`.
- `out_addr` out DATAW: `lincount - IN_OUT_LAT*IOVECT`.
- `lincount` out DATAW: current linear index.
- `wi_count` out DATAW: completed work instances.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse at end of run.
- `err_ovalid` out 1: sticky; set on `k_ovalid` ≠ `out_wr_en` in any RUN cycle.

## Operation
- **States**
  - IDLE → RUN on `start`. The same edge clears `lincount`, `wi_count` and `err_ovalid`.
  - RUN → DONE on the last beat of the last work instance.
  - DONE → IDLE unconditionally. `done` = 1 only in DONE.
- **Beat issue:** `k_ivalid` = RUN & `src_ok` & ~`throttle`. The combinational term is a registered state ANDed with the inputs. Counters advance only on a `k_ivalid` cycle.
- **Beat classification:** `LAST_IDX` = `SIZE - IOVECT + IN_OUT_LAT*IOVECT`.
  - `in_rd_en` = `k_ivalid` & (`lincount` < `SIZE`).
  - `pad` = `k_ivalid` & (`lincount` ≥ `SIZE`).
  - `out_wr_en` = `k_ivalid` & (`lincount` ≥ `IN_OUT_LAT*IOVECT`).
- **Index update on a beat:**
  - If `lincount` = `LAST_IDX`: `lincount` ← 0 and `wi_count` += 1.
  - Otherwise: `lincount` += `IOVECT`.
- **End of run:** when `wi_count` reaches `NWI`, the state goes to DONE; otherwise the next work instance starts with no gap.
- **Arithmetic:** unsigned DATAW-bit. Compare `out_addr` only under `out_wr_en`, because it wraps below 0 otherwise.
- **Ignored inputs:** `start` in RUN or DONE has no effect. `src_ok` and `k_ovalid` have no effect in IDLE.
- **Reset:** `resetn` low at any time, including mid-run, forces IDLE. All outputs and counters go to 0 and the throttle LFSR returns to its seed.

## Timing
- `start` high at edge N gives RUN from cycle N+1. The first `k_ivalid` can occur in cycle N+1.
- Unthrottled, with `src_ok` = 1, a run takes `NWI*(SIZE/IOVECT + IN_OUT_LAT)` beat cycles, plus 1 DONE cycle.
- A stall (`src_ok` = 0 or throttle) holds every counter and deasserts all strobes in that cycle.
- `busy` falls in the cycle after DONE.

## Configuration
- **`KSTREAM_THROTTLE_EN` defined:** a 16-bit Fibonacci LFSR runs every RUN cycle.
  - Taps 16, 14, 13, 11; seed `16'hACE1`.
  - `throttle` asserts when `lfsr[3:0]` = 0. A 2-bit hold counter then keeps it asserted for a further `lfsr[5:4]` cycles, i.e. 0–3.
  - Purpose: emulate shell back-pressure for robustness tests.
- **Undefined:** `throttle` is constant 0, and no LFSR or hold-counter logic is synthesized.

## Structure
- **Package `kstream_pkg`:**
  - state enum `{IDLE, RUN, DONE}`;
  - functions computing `LAST_IDX` and the pad start from the parameters;
  - the LFSR seed constant.
- **Sub-module `kstream_throttle`:** holds the LFSR and hold counter. Its ports are `clock`, `resetn`, `en`, `throttle`. It is instantiated only under `KSTREAM_THROTTLE_EN`.

## Test plan
All scenarios use `SIZE` = 8, `IN_OUT_LAT` = 3, `IOVECT` = 1, `NWI` = 1 and `src_ok` = 1 unless stated. Throttle is off except in scenario 5.
1. **Basic run:** `start` at cycle 0 → `k_ivalid` cycles 1–11.
   - `in_rd_en` cycles 1–8 with `in_addr` 0–7; `pad` cycles 9–11.
   - `out_wr_en` cycles 4–11 with `out_addr` 0–7.
   - `done` cycle 12; `busy` low cycle 13; `wi_count` = 1.
2. **Source stalls:** `src_ok` low in cycles 3–5 → no strobes in cycles 3–5; `lincount` holds at 2; `done` at cycle 15.
3. **Multiple instances:** `NWI` = 3 → `lincount` wraps 10 → 0 with no gap; `wi_count` steps 1, 2, 3; `done` at cycle 34.
4. **Reset and re-arm:** `resetn` low at cycle 6 with `lincount` = 5 → next cycle everything is 0 and the state is IDLE. A new `start` reproduces scenario 1 exactly.
5. **Throttled run:** `KSTREAM_THROTTLE_EN` defined, `SIZE` = 64 → exactly 64 `in_rd_en` and 64 `out_wr_en` events, and addresses are monotonic without gaps.
6. **Ovalid check and start masking:** a kernel model drops `k_ovalid` at output beat 4 → `err_ovalid` sets and holds until the next `start`. In a separate run, `start` pulsed during RUN → no restart and `lincount` unaffected.
